// File: rtl/bht_pkg.sv
// Shared types and helpers for the gshare branch history table.
package bht_pkg;

    // Table sweep state: normal operation or flush-clear in progress.
    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } bht_state_e;

    // Widest counter the helpers below support.
    localparam int unsigned CNT_W_MAX = 16;

    // Weakly not-taken reset value: 2^(cnt_w-1) - 1.
    function automatic logic [CNT_W_MAX-1:0] cnt_init(input int unsigned cnt_w);
        return CNT_W_MAX'((32'd1 << (cnt_w - 1)) - 32'd1);
    endfunction

    // Saturating up/down step of a cnt_w-bit counter; never wraps.
    function automatic logic [CNT_W_MAX-1:0] sat_update(input logic [CNT_W_MAX-1:0] cnt,
                                                         input logic                 taken,
                                                         input int unsigned          cnt_w);
        logic [CNT_W_MAX-1:0] v_max;
        v_max = CNT_W_MAX'((32'd1 << cnt_w) - 32'd1);
        if (taken)
            return (cnt == v_max) ? cnt : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/gshare_bht.sv
// gshare predictor: saturating counters indexed by PC ^ speculative global
// history, registered one-cycle prediction, checkpoint-based GHR repair and a
// one-entry-per-cycle flush sweep of the table.
module gshare_bht
    import bht_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int G_DEPTH = 4,
    parameter int CNT_W   = 2,
    parameter int PC_LSB  = 2,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               pred_req,
    input  logic [31:0]        pred_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [IDX_W-1:0]   pred_idx,
    output logic [G_DEPTH-1:0] pred_ghr,
    input  logic               upd_en,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    input  logic [G_DEPTH-1:0] upd_ghr,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    bht_state_e                    r_state, w_state_next;
    logic [IDX_W-1:0]              r_ptr;
    logic [G_DEPTH-1:0]            r_ghr;
    logic [DEPTH-1:0][CNT_W-1:0]   r_cnt;

    logic                          r_pred_valid;
    logic                          r_pred_taken;
    logic [IDX_W-1:0]              r_pred_idx;
    logic [G_DEPTH-1:0]            r_pred_ghr;

    logic                          w_live;
    logic                          w_recover;
    logic                          w_accept;
    logic                          w_write;
    logic [IDX_W-1:0]              w_idx;
    logic                          w_rd_taken;
    logic [CNT_W-1:0]              w_cnt_next;

    // Flush takes priority over any traffic in the same cycle.
    assign w_live     = (r_state == IDLE) && !flush;
    assign w_recover  = w_live && upd_en && upd_mispredict;
    assign w_accept   = w_live && pred_req && !(upd_en && upd_mispredict);
    assign w_write    = w_live && upd_en;
    assign w_idx      = pred_pc[PC_LSB +: IDX_W] ^ IDX_W'(r_ghr);
    assign w_rd_taken = r_cnt[w_idx][CNT_W-1];
    assign w_cnt_next = CNT_W'(sat_update(CNT_W_MAX'(r_cnt[upd_idx]), upd_taken, CNT_W));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state: flush (re)starts the sweep, last entry ends it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (flush) w_state_next = INIT;
            INIT: if (!flush && r_ptr == LAST_IDX) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Sweep pointer and global history; recovery overrides the speculative shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else if (flush) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else if (r_state == INIT) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (w_recover) begin
            r_ghr <= G_DEPTH'({upd_ghr, upd_taken});
        end else if (w_accept) begin
            r_ghr <= G_DEPTH'({r_ghr, w_rd_taken});
        end
    end

    // Counter array: sweep clear in INIT, saturating training in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_INIT;
        end else if (r_state == INIT) begin
            r_cnt[r_ptr] <= CNT_INIT;
        end else if (w_write) begin
            r_cnt[upd_idx] <= w_cnt_next;
        end
    end

    // Registered prediction; the fields hold their last value when not valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= w_accept;
            if (w_accept) begin
                r_pred_taken <= w_rd_taken;
                r_pred_idx   <= w_idx;
                r_pred_ghr   <= r_ghr;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_idx   = r_pred_idx;
    assign pred_ghr   = r_pred_ghr;
    assign busy       = (r_state == INIT);

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht with a cycle-level reference model.
module tb_gshare_bht;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_valid, pred_taken;
    logic [6:0]  pred_idx;
    logic [3:0]  pred_ghr;
    logic        upd_en = 1'b0;
    logic [6:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [3:0]  upd_ghr = '0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    gshare_bht dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: table of plain ints, history as an int, sweep as a countdown.
    int m_cnt[128];
    int m_ghr = 0, m_sw = 0;
    int m_valid = 0, m_taken = 0, m_idx = 0, m_pghr = 0;
    int m_i, m_t, m_rec, m_c;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) m_cnt[i] = 1;
            m_ghr = 0; m_sw = 0;
            m_valid = 0; m_taken = 0; m_idx = 0; m_pghr = 0;
        end else if (flush) begin
            for (int i = 0; i < 128; i++) m_cnt[i] = 1;
            m_ghr = 0; m_sw = 128; m_valid = 0;
        end else if (m_sw > 0) begin
            m_sw = m_sw - 1; m_valid = 0;
        end else begin
            m_i   = ((int'(pred_pc) >> 2) & 127) ^ m_ghr;
            m_t   = (m_cnt[m_i] >= 2) ? 1 : 0;
            m_rec = (upd_en && upd_mispredict) ? 1 : 0;
            m_valid = (pred_req && m_rec == 0) ? 1 : 0;
            if (m_valid == 1) begin
                m_taken = m_t; m_idx = m_i; m_pghr = m_ghr;
            end
            if (m_rec == 1)        m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & 15;
            else if (m_valid == 1) m_ghr = ((m_ghr << 1) | m_t) & 15;
            if (upd_en) begin
                m_c = m_cnt[int'(upd_idx)];
                if (upd_taken) m_c = (m_c < 3) ? m_c + 1 : 3;
                else           m_c = (m_c > 0) ? m_c - 1 : 0;
                m_cnt[int'(upd_idx)] = m_c;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("busy", int'(busy), (m_sw > 0) ? 1 : 0);
        chk("pred_valid", int'(pred_valid), m_valid);
        if (m_valid == 1) begin
            chk("pred_taken", int'(pred_taken), m_taken);
            chk("pred_idx", int'(pred_idx), m_idx);
            chk("pred_ghr", int'(pred_ghr), m_pghr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input int idx, input bit tk, input bit mis, input int g);
        upd_en = 1'b1; upd_idx = 7'(idx); upd_taken = tk;
        upd_mispredict = mis; upd_ghr = 4'(g);
        cyc();
        upd_en = 1'b0; upd_mispredict = 1'b0;
    endtask

    // Request a prediction that lands on table entry idx given the current history.
    task automatic pred_at(input string name, input int idx, input int exp_taken);
        pred_pc = 32'((idx ^ m_ghr) << 2); pred_req = 1'b1;
        cyc();
        pred_req = 1'b0;
        chk({name, ".valid"}, int'(pred_valid), 1);
        chk({name, ".idx"}, int'(pred_idx), idx);
        chk({name, ".taken"}, int'(pred_taken), exp_taken);
    endtask

    int n;
    int exp_up[4]  = '{1, 1, 1, 1};
    int exp_dn[5]  = '{1, 0, 0, 0, 0};

    initial begin
        #1 reset = 1'b1;
        repeat (2) cyc();
        chk("rst.busy", int'(busy), 0);
        chk("rst.valid", int'(pred_valid), 0);
        chk("rst.idx", int'(pred_idx), 0);
        chk("rst.ghr", int'(pred_ghr), 0);
        reset = 1'b0;
        cyc();

        // 1: first prediction
        pred_pc = 32'h100; pred_req = 1'b1;
        cyc();
        pred_req = 1'b0;
        chk("t1.valid", int'(pred_valid), 1);
        chk("t1.taken", int'(pred_taken), 0);
        chk("t1.idx", int'(pred_idx), 'h40);
        chk("t1.ghr", int'(pred_ghr), 0);
        chk("t1.model_ghr", m_ghr, 0);
        pred_pc = 32'h0; pred_req = 1'b1;
        cyc();
        pred_req = 1'b0;
        chk("t1.ghr_stays", int'(pred_ghr), 0);

        // 2: saturating counter at entry 5
        for (int k = 0; k < 4; k++) begin
            upd(5, 1'b1, 1'b0, 0);
            pred_at("t2.up", 5, exp_up[k]);
        end
        for (int k = 0; k < 5; k++) begin
            upd(5, 1'b0, 1'b0, 0);
            pred_at("t2.dn", 5, exp_dn[k]);
        end
        chk("t2.model_cnt", m_cnt[5], 0);

        // 3: mispredict recovery of the history
        upd(20, 1'b1, 1'b1, 'b0101);
        chk("t3.model_ghr", m_ghr, 'b1011);
        pred_pc = 32'h0; pred_req = 1'b1;
        cyc();
        pred_req = 1'b0;
        chk("t3.idx", int'(pred_idx), 'h0B);
        chk("t3.ghr", int'(pred_ghr), 'b1011);

        // 4: same-cycle read/write returns the old counter, then the new one
        pred_pc = 32'((7 ^ m_ghr) << 2); pred_req = 1'b1;
        upd_en = 1'b1; upd_idx = 7'd7; upd_taken = 1'b1;
        cyc();
        pred_req = 1'b0; upd_en = 1'b0;
        chk("t4.old_taken", int'(pred_taken), 0);
        chk("t4.old_idx", int'(pred_idx), 7);
        pred_at("t4.new", 7, 1);
        pred_pc = 32'h0; pred_req = 1'b1;
        upd_en = 1'b1; upd_mispredict = 1'b1; upd_idx = 7'd9; upd_taken = 1'b0; upd_ghr = 4'd0;
        cyc();
        pred_req = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
        chk("t4.mis_blocks", int'(pred_valid), 0);

        // 5: flush sweep
        upd(3, 1'b1, 1'b0, 0);
        upd(3, 1'b1, 1'b0, 0);
        pred_at("t5.trained", 3, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            if (n == 10) begin pred_pc = 32'h0; pred_req = 1'b1; end
            if (n == 11) begin
                pred_req = 1'b0;
                chk("t5.blocked", int'(pred_valid), 0);
            end
            cyc();
        end
        chk("t5.busy_len", n, 128);
        chk("t5.model_ghr", m_ghr, 0);
        pred_at("t5.cleared", 3, 0);
        chk("t5.ghr", int'(pred_ghr), 0);

        // 6: reset in the middle of a sweep
        upd(3, 1'b1, 1'b0, 0);
        upd(3, 1'b1, 1'b0, 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (40) cyc();
        chk("t6.busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6.busy_async", int'(busy), 0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) pred_at("t6.init", (k * 17 + 3) & 127, 0);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gshare_bht.md
# gshare_bht

Parametrised gshare branch history table for the fetch stage: an array of CNT_W-bit saturating counters indexed by PC XOR global history. It gives a registered taken/not-taken prediction one cycle after a request, and keeps a speculative global history register (GHR). On a mispredict it repairs the GHR from a checkpoint supplied by execute. It also provides a sweep-based flush of the whole table.

## Interface
- DEPTH, 128: counter entries; power of two. IDX_W = $clog2(DEPTH).
- G_DEPTH, 4: global history bits; 1 ≤ G_DEPTH ≤ IDX_W.
- CNT_W, 2: counter width; ≥ 2.
- PC_LSB, 2: lowest PC bit used for indexing.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  start table-clear sweep.
- pred_req  in  1  prediction request.
- pred_pc  in  32  PC to predict.
- pred_valid  out  1  prediction valid (one cycle after an accepted pred_req).
- pred_taken  out  1  predicted direction (counter MSB).
- pred_idx  out  IDX_W  table index used; carried down the pipe to update.
- pred_ghr  out  G_DEPTH  GHR before this prediction's speculative shift (recovery checkpoint).
- upd_en  in  1  resolve/update strobe.
- upd_idx  in  IDX_W  index to train.
- upd_taken  in  1  resolved direction.
- upd_mispredict  in  1  resolved direction differed from the prediction.
- upd_ghr  in  G_DEPTH  checkpoint returned with the branch.
- busy  out  1  flush sweep in progress.

## Operation
- Index = pred_pc[PC_LSB +: IDX_W] ^ {zero-extended ghr}.
- States: IDLE and INIT.
  - reset → IDLE.
  - IDLE + flush → INIT, with ptr = 0 and ghr = 0.
  - INIT → IDLE after the write to ptr == DEPTH-1.
  - flush in INIT restarts the sweep: ptr = 0.
- INIT behaviour:
  - writes CNT_INIT to entry ptr each cycle, ptr += 1.
  - pred_req, upd_en and upd_mispredict are ignored; pred_valid = 0.
- pred_req in IDLE is accepted unless upd_mispredict is high the same cycle.
- Accepted request, next cycle:
  - pred_valid = 1.
  - pred_taken = counter[index][CNT_W-1].
  - pred_idx = index.
  - pred_ghr = ghr as it was before the shift.
  - ghr ← {ghr[G_DEPTH-2:0], predicted taken}. For G_DEPTH = 1, ghr ← predicted taken.
- Counter update, when upd_en is high in IDLE:
  - upd_taken and counter ≠ 2^CNT_W-1 → +1.
  - !upd_taken and counter ≠ 0 → -1.
  - Otherwise the counter holds; it never wraps.
- Recovery, when upd_en && upd_mispredict in IDLE: ghr ← {upd_ghr[G_DEPTH-2:0], upd_taken}. This overrides any speculative shift that cycle.
- upd_mispredict without upd_en is ignored.
- Read and write to the same index in the same cycle: the prediction returns the pre-update value. There is no bypass.
- CNT_INIT = 2^(CNT_W-1)-1, i.e. weakly not-taken (2'b01).
- Reset values:
  - every counter = CNT_INIT (asynchronous).
  - ghr = 0, ptr = 0.
  - pred_valid = pred_taken = 0, pred_idx = 0, pred_ghr = 0.
  - busy = 0.

## Timing
- Prediction latency 1 cycle; one request per cycle sustained; no backpressure.
- Update: the counter write is visible to a pred_req issued on the following cycle.
- Recovered ghr is used by a pred_req issued on the following cycle.
- Flush: busy rises the cycle after flush and stays high exactly DEPTH cycles.
- Reset assertion mid-INIT: immediately state = IDLE, busy = 0, all counters = CNT_INIT.

## Structure
- Shared package bht_pkg holds:
  - state enum {IDLE, INIT}.
  - function sat_update(cnt, taken) parametrised on CNT_W.
  - CNT_INIT computation.
- The counter array, GHR and FSM stay inline in gshare_bht. No sub-module is needed; the array is flop-based so the async reset applies to every entry.

## Test plan
All scenarios use the defaults: DEPTH=128, G_DEPTH=4, CNT_W=2, PC_LSB=2.
1. Reset, then pred_req with pred_pc=0x100 → next cycle pred_valid=1, pred_taken=0, pred_idx=0x40, pred_ghr=0; ghr stays 4'b0000.
2. upd_en, upd_taken=1, upd_idx=5, ×3 → counter 2'b11; a 4th taken update holds 11. Then not-taken ×4 → 00; a 5th holds 00. Prediction checks at index 5 after each step return the MSB.
3. upd_en + upd_mispredict, upd_ghr=4'b0101, upd_taken=1 → ghr=4'b1011. Next pred_req with pc=0 → pred_idx=0x0B, pred_ghr=4'b1011.
4. Same cycle: pred_req at index 7 and a taken update to index 7 → returns the old value (taken=0). The next request returns the new counter 10 → taken=1. pred_req together with upd_mispredict → pred_valid=0 the following cycle.
5. Train index 3 to 11, then pulse flush → busy high for exactly 128 cycles, pred_req during the sweep gives pred_valid=0. Afterwards, a request hitting index 3 gives pred_taken=0 and ghr=0.
6. Assert reset at sweep cycle 40 → busy=0 asynchronously. After release, all entries predict not-taken and the table accepts requests immediately.
